// File: rtl/shake_hand_send.sv
// Transmit side of the 4-phase ready/ack byte handshake: bytes queue in a small
// FIFO and are offered one at a time on dout/ready until acknowledged or timed out.
module shake_hand_send #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic [7:0]  wr_data,
    output logic        full,
    output logic        empty,
    output logic [7:0]  dout,
    output logic        ready,
    input  logic        ack,
    output logic        busy,
    output logic        err,
    output logic [15:0] sent_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, WAIT_HI, WAIT_LO} state_t;

    state_t        state_q, state_d;
    logic [7:0]    mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q, rd_ptr_q;
    logic          ack_m_q, ack_s_q;
    logic [CW-1:0] tmo_q, tmo_d;
    logic [7:0]    dout_q, dout_d;
    logic          ready_q, ready_d;
    logic          err_q, err_d;
    logic [15:0]   sent_q, sent_d;
    logic          push, pop;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push  = wr_en && !full;

    assign dout     = dout_q;
    assign ready    = ready_q;
    assign err      = err_q;
    assign sent_cnt = sent_q;
    assign busy     = (state_q != IDLE);

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        dout_d  = dout_q;
        ready_d = ready_q;
        err_d   = 1'b0;
        sent_d  = sent_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    dout_d  = mem_q[rd_ptr_q[AW-1:0]];
                    pop     = 1'b1;
                    ready_d = 1'b1;
                    tmo_d   = '0;
                    state_d = WAIT_HI;
                end
            end
            WAIT_HI: begin
                // An ack arriving on the last timeout cycle still counts the word.
                if (ack_s_q) begin
                    ready_d = 1'b0;
                    sent_d  = sent_q + 16'd1;
                    state_d = WAIT_LO;
                end else if (tmo_q == TO_LAST) begin
                    ready_d = 1'b0;
                    err_d   = 1'b1;
                    state_d = WAIT_LO;
                end else begin
                    tmo_d = tmo_q + CW'(1);
                end
            end
            WAIT_LO: begin
                ready_d = 1'b0;
                if (!ack_s_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                ready_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ack_m_q  <= 1'b0;
            ack_s_q  <= 1'b0;
            tmo_q    <= '0;
            dout_q   <= 8'h00;
            ready_q  <= 1'b0;
            err_q    <= 1'b0;
            sent_q   <= 16'h0000;
        end else begin
            state_q <= state_d;
            ack_m_q <= ack;
            ack_s_q <= ack_m_q;
            tmo_q   <= tmo_d;
            dout_q  <= dout_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            sent_q  <= sent_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

endmodule
